// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache memory-port arbiter.
// Widths, FSM states and requester identifiers.
package cache_arb_pkg;

  localparam int S_ADDR = 32;
  localparam int S_LINE = 256;

  typedef enum logic [1:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } arb_req_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Two-way round-robin winner selection.
// On a tie the side not granted last time wins.
module arb_rr_pick
  import cache_arb_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_req_t last,
  output logic     valid,
  output arb_req_t pick
);

  always_comb begin
    valid = i_req | d_req;
    pick  = REQ_I;
    unique case (1'b1)
      i_req & d_req:  pick = (last == REQ_I) ? REQ_D : REQ_I;
      d_req & ~i_req: pick = REQ_D;
      default:        pick = REQ_I;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache.
// One transaction at a time; pmem command is registered at grant.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int s_addr  = S_ADDR,
  parameter int s_line  = S_LINE,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state, state_nxt;
  arb_req_t          last, last_nxt;
  logic [s_addr-1:0] addr_nxt;
  logic [s_line-1:0] wdata_nxt;
  logic              read_nxt, write_nxt;
  logic              grant_ok;
  arb_req_t          pick;

  arb_rr_pick u_pick (
    .i_req (i_pmem_read),
    .d_req (d_pmem_read | d_pmem_write),
    .last  (last),
    .valid (grant_ok),
    .pick  (pick)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    addr_nxt  = pmem_address;
    wdata_nxt = pmem_wdata;
    read_nxt  = pmem_read;
    write_nxt = pmem_write;
    unique case (state)
      IDLE: begin
        if (grant_ok) begin
          last_nxt = pick;
          if (pick == REQ_I) begin
            addr_nxt  = i_pmem_address;
            read_nxt  = 1'b1;
            state_nxt = I_READ;
          end else begin
            addr_nxt  = d_pmem_address;
            wdata_nxt = d_pmem_wdata;
            // write wins if a cache ever raises both strobes
            if (d_pmem_write) begin
              write_nxt = 1'b1;
              state_nxt = D_WRITE;
            end else begin
              read_nxt  = 1'b1;
              state_nxt = D_READ;
            end
          end
        end
      end
      default: begin
        if (pmem_resp) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= D_FIRST ? REQ_I : REQ_D;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else begin
      state        <= state_nxt;
      last         <= last_nxt;
      pmem_address <= addr_nxt;
      pmem_wdata   <= wdata_nxt;
      pmem_read    <= read_nxt;
      pmem_write   <= write_nxt;
    end
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = pmem_resp & (state == I_READ);
  assign d_pmem_resp  = pmem_resp &
                        ((state == D_READ) | (state == D_WRITE));

  a_d_rw_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(d_pmem_read && d_pmem_write)
  );

  a_idle_resp: assert property (
    @(posedge clk) disable iff (rst)
    !(pmem_resp && state == IDLE)
  ) else $warning("pmem_resp while idle ignored");

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter.
// Directed stimulus; monitor checks grants and responses.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_read;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter #(.D_FIRST(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_d;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } grant_t;

  typedef struct packed {
    logic         is_d;
    logic [255:0] data;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  grant_t g;
  resp_t  r;
  int     n_tests = 0;
  int     n_fail  = 0;
  logic   strobe_prev = 1'b0;
  logic   strobe_now;

  localparam logic [255:0] DAT_A5 = {32{8'hA5}};
  localparam logic [255:0] DAT_DE = {16{16'hDEAD}};
  localparam logic [255:0] DAT_D1 = {8{32'h1111_D00D}};
  localparam logic [255:0] DAT_I1 = {8{32'h2222_1CED}};
  localparam logic [255:0] DAT_D4 = {8{32'h4444_0100}};
  localparam logic [255:0] DAT_I2 = {8{32'h5555_2020}};
  localparam logic [255:0] DAT_D2 = {8{32'h6666_3030}};

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: grants on strobe rise, completions on resp
  always @(negedge clk) begin
    strobe_now = pmem_read | pmem_write;
    if (rst !== 1'b1 && strobe_now === 1'b1 && strobe_prev !== 1'b1) begin
      if (gq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL grant_unexp: addr %0h", pmem_address);
      end else begin
        g = gq.pop_front();
        check("grant_addr", pmem_address, g.addr);
        check("grant_op", {pmem_write, pmem_read}, g.wr ? 2'b10 : 2'b01);
        if (g.wr) check("grant_wdata", pmem_wdata, g.wdata);
      end
    end
    strobe_prev = strobe_now;
    if (i_pmem_resp === 1'b1 || d_pmem_resp === 1'b1) begin
      if (rq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexp: i %0b d %0b", i_pmem_resp, d_pmem_resp);
      end else begin
        r = rq.pop_front();
        check("resp_side", {d_pmem_resp, i_pmem_resp}, r.is_d ? 2'b10 : 2'b01);
        check("resp_data", r.is_d ? d_pmem_rdata : i_pmem_rdata, r.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(string name);
    for (int k = 0; k < 20; k++) begin
      if (pmem_read || pmem_write) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: strobe timeout got 0 want 1", name);
  endtask

  // memory answers lat cycles after grant; requester drops after resp
  task automatic serve(string name, int lat, logic is_d, logic [255:0] data);
    wait_strobe(name);
    repeat (lat) tick();
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    @(negedge clk);
    check({name, "_resp_now"}, {d_pmem_resp, i_pmem_resp},
          is_d ? 2'b10 : 2'b01);
    tick();
    pmem_resp = 1'b0;
    if (is_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
    @(negedge clk);
    check({name, "_strobe_off"}, {pmem_write, pmem_read}, 2'b00);
  endtask

  initial begin
    rst            = 1'b1;
    i_pmem_address = '0;
    i_pmem_read    = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_strobes", {pmem_write, pmem_read}, 2'b00);
    check("rst_addr", pmem_address, 32'h0);
    check("rst_wdata", pmem_wdata, 256'h0);

    // I-only read
    tick();
    i_pmem_address = 32'h0000_0060;
    i_pmem_read    = 1'b1;
    gq.push_back('{1'b0, 1'b0, 32'h60, 256'h0});
    rq.push_back('{1'b0, DAT_A5});
    tick();
    @(negedge clk);
    check("t1_read_n1", pmem_read, 1'b1);
    serve("t1", 5, 1'b0, DAT_A5);

    // D writeback
    tick();
    d_pmem_address = 32'h0000_1020;
    d_pmem_wdata   = DAT_DE;
    d_pmem_write   = 1'b1;
    gq.push_back('{1'b1, 1'b1, 32'h1020, DAT_DE});
    rq.push_back('{1'b1, 256'h0});
    tick();
    @(negedge clk);
    check("t2_write_n1", {pmem_write, pmem_read}, 2'b10);
    serve("t2", 3, 1'b1, 256'h0);

    // simultaneous pair after reset: D first, then I
    tick();
    do_reset();
    i_pmem_address = 32'h0000_0400;
    d_pmem_address = 32'h0000_0800;
    i_pmem_read    = 1'b1;
    d_pmem_read    = 1'b1;
    gq.push_back('{1'b1, 1'b0, 32'h800, 256'h0});
    gq.push_back('{1'b0, 1'b0, 32'h400, 256'h0});
    rq.push_back('{1'b1, DAT_D1});
    rq.push_back('{1'b0, DAT_I1});
    tick();
    serve("t3a", 2, 1'b1, DAT_D1);
    tick();
    @(negedge clk);
    check("t3_bubble_regrant", {pmem_write, pmem_read}, 2'b01);
    serve("t3b", 2, 1'b0, DAT_I1);

    // address change after grant is ignored
    tick();
    d_pmem_address = 32'h0000_0100;
    d_pmem_read    = 1'b1;
    gq.push_back('{1'b1, 1'b0, 32'h100, 256'h0});
    rq.push_back('{1'b1, DAT_D4});
    tick();
    @(negedge clk);
    d_pmem_address = 32'h0000_0200;
    tick();
    tick();
    @(negedge clk);
    check("t4_addr_held", pmem_address, 32'h100);
    serve("t4", 1, 1'b1, DAT_D4);

    // second pair: last grant was D, so I goes first
    tick();
    i_pmem_address = 32'h0000_0a00;
    d_pmem_address = 32'h0000_0b00;
    i_pmem_read    = 1'b1;
    d_pmem_read    = 1'b1;
    gq.push_back('{1'b0, 1'b0, 32'ha00, 256'h0});
    gq.push_back('{1'b1, 1'b0, 32'hb00, 256'h0});
    rq.push_back('{1'b0, DAT_I2});
    rq.push_back('{1'b1, DAT_D2});
    tick();
    serve("t3c", 2, 1'b0, DAT_I2);
    tick();
    serve("t3d", 2, 1'b1, DAT_D2);

    // reset mid D_READ abandons the transaction
    tick();
    d_pmem_address = 32'h0000_0300;
    d_pmem_read    = 1'b1;
    gq.push_back('{1'b1, 1'b0, 32'h300, 256'h0});
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    d_pmem_read = 1'b0;
    pmem_rdata  = DAT_A5;
    pmem_resp   = 1'b1;
    @(negedge clk);
    check("t5_no_resp", {d_pmem_resp, i_pmem_resp}, 2'b00);
    check("t5_strobe_off", {pmem_write, pmem_read}, 2'b00);
    tick();
    pmem_resp = 1'b0;

    // spurious resp in IDLE
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    check("t6_no_resp", {d_pmem_resp, i_pmem_resp}, 2'b00);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("t6_idle", {pmem_write, pmem_read}, 2'b00);

    tick();
    tick();
    check("gq_drained", gq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
